// File: rtl/serial_tx_queue.sv
// Show-ahead word FIFO feeding the async serial transmitter (serial_clk domain).
// Define SERIAL_TX_QUEUE_OVERFLOW_EN to build the sticky overflow flag.
module serial_tx_queue #(
  parameter int BITS      = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 serial_clk,
  input  logic                 in_rst,
  input  logic                 in_wr_valid,
  output logic                 out_wr_ready,
  input  logic [BITS-1:0]      in_wr_data,
  input  logic                 in_flush,
  output logic                 out_tx_enable,
  output logic [BITS-1:0]      out_tx_word,
  input  logic                 in_tx_next_word,
  input  logic                 in_tx_ready,
  output logic [ADDR_BITS:0]   out_count,
  output logic                 out_overflow
);

  localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS+1)'(DEPTH);

  logic [BITS-1:0]      mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 keep;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = in_wr_valid && !full && !in_flush;
  assign pop   = in_tx_next_word && !empty && !in_flush;
  // Flush keeps the head only while the transmitter is serialising it
  assign keep  = !in_tx_ready && !empty;

  always_ff @(posedge serial_clk or posedge in_rst) begin
    if (in_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (in_flush) begin
      wr_ptr <= rd_ptr + ADDR_BITS'(keep);
      count  <= (ADDR_BITS+1)'(keep);
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge serial_clk) begin
    if (push) mem[wr_ptr] <= in_wr_data;
  end

  assign out_wr_ready  = !full;
  assign out_tx_enable = !empty;
  assign out_tx_word   = empty ? '0 : mem[rd_ptr];
  assign out_count     = count;

`ifdef SERIAL_TX_QUEUE_OVERFLOW_EN
  logic overflow;
  logic drop;

  assign drop = in_wr_valid && full && !in_flush;

  always_ff @(posedge serial_clk or posedge in_rst) begin
    if (in_rst)        overflow <= 1'b0;
    else if (drop)     overflow <= 1'b1;
    else if (in_flush) overflow <= 1'b0;
  end

  assign out_overflow = overflow;
`else
  assign out_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_tx_queue.sv
// Directed self-checking bench for serial_tx_queue, with a small 8N1 transmitter model.
module tb_serial_tx_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       flush;
  logic       tx_enable;
  logic [7:0] tx_word;
  logic       next_word;
  logic       nw_drv;
  logic       tx_ready;
  logic [4:0] count;
  logic       overflow;
  logic       use_tx;

  int checks   = 0;
  int failures = 0;

`ifdef SERIAL_TX_QUEUE_OVERFLOW_EN
  localparam logic OV = 1'b1;
`else
  localparam logic OV = 1'b0;
`endif

  always #5 clk = ~clk;

  serial_tx_queue dut (
    .serial_clk      (clk),
    .in_rst          (rst),
    .in_wr_valid     (wr_valid),
    .out_wr_ready    (wr_ready),
    .in_wr_data      (wr_data),
    .in_flush        (flush),
    .out_tx_enable   (tx_enable),
    .out_tx_word     (tx_word),
    .in_tx_next_word (next_word),
    .in_tx_ready     (tx_ready),
    .out_count       (count),
    .out_overflow    (overflow)
  );

  // Transmitter model: one bit per clock, re-latches the word each enabled cycle
  logic [3:0] bc;
  logic [9:0] frame;
  logic       line;
  logic       model_nw;

  assign frame     = {1'b1, tx_word, 1'b0};
  assign line      = tx_enable ? frame[bc] : 1'b1;
  assign model_nw  = tx_enable && (bc == 4'd9);
  assign next_word = use_tx ? model_nw : nw_drv;

  always @(posedge clk or posedge rst) begin
    if (rst)            bc <= 4'd0;
    else if (!tx_enable) bc <= 4'd0;
    else if (bc == 4'd9) bc <= 4'd0;
    else                bc <= bc + 4'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pop();
    nw_drv = 1'b1;
    tick();
    nw_drv = 1'b0;
  endtask

  logic [20:0] got;
  logic [20:0] want;

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; flush = 1'b0;
    nw_drv = 1'b0; tx_ready = 1'b1; use_tx = 1'b0;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_enable", 32'(tx_enable), 0);
    check("rst_word", 32'(tx_word), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_overflow", 32'(overflow), 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    push(8'hA5);
    check("t1_enable", 32'(tx_enable), 1);
    check("t1_word", 32'(tx_word), 32'hA5);
    check("t1_count", 32'(count), 1);
    pop();
    check("t1_pop_count", 32'(count), 0);

    push(8'h11); push(8'h22); push(8'h33);
    check("t2_word0", 32'(tx_word), 32'h11);
    check("t2_count", 32'(count), 3);
    pop();
    repeat (10) tick();
    check("t2_word1", 32'(tx_word), 32'h22);
    pop();
    repeat (10) tick();
    check("t2_word2", 32'(tx_word), 32'h33);
    pop();
    check("t2_enable", 32'(tx_enable), 0);
    check("t2_word_empty", 32'(tx_word), 0);
    check("t2_count_empty", 32'(count), 0);

    nw_drv = 1'b1; tick(); nw_drv = 1'b0;
    check("pop_empty_ignored", 32'(count), 0);

    for (int i = 0; i < 16; i++) push(8'(i));
    check("t3_count", 32'(count), 16);
    check("t3_wr_ready", 32'(wr_ready), 0);
    check("t3_head", 32'(tx_word), 32'h00);
    push(8'hFF);
    check("t3_count_drop", 32'(count), 16);
    check("t3_overflow", 32'(overflow), 32'(OV));

    wr_valid = 1'b1; wr_data = 8'h77; nw_drv = 1'b1;
    tick();
    wr_valid = 1'b0; nw_drv = 1'b0;
    check("t4_count", 32'(count), 15);
    check("t4_head", 32'(tx_word), 32'h01);
    push(8'h77);
    check("t4_count_full", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4_pop%0d", i), 32'(tx_word),
            (i < 15) ? 32'(i + 1) : 32'h77);
      pop();
    end
    check("t4_empty", 32'(count), 0);
    check("t4_overflow_sticky", 32'(overflow), 32'(OV));

    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    tx_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; tx_ready = 1'b1;
    check("t5_keep_count", 32'(count), 1);
    check("t5_keep_head", 32'(tx_word), 32'h50);
    check("t5_keep_enable", 32'(tx_enable), 1);
    check("t5_overflow_clr", 32'(overflow), 0);
    for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
    check("t5_refill_count", 32'(count), 5);
    check("t5_refill_head", 32'(tx_word), 32'h50);
    flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h99;
    tick();
    flush = 1'b0; wr_valid = 1'b0;
    check("t5_flush_count", 32'(count), 0);
    check("t5_flush_enable", 32'(tx_enable), 0);

    wr_valid = 1'b1; wr_data = 8'hC3; nw_drv = 1'b1;
    tick();
    wr_valid = 1'b0; nw_drv = 1'b0;
    check("push_pop_empty", 32'(count), 1);
    push(8'hC4);
    wr_valid = 1'b1; wr_data = 8'hC5; nw_drv = 1'b1;
    tick();
    wr_valid = 1'b0; nw_drv = 1'b0;
    check("push_pop_mid_count", 32'(count), 2);
    check("push_pop_mid_head", 32'(tx_word), 32'hC4);
    flush = 1'b1; tick(); flush = 1'b0;

    use_tx = 1'b1;
    push(8'h41);
    got[0] = line;
    wr_valid = 1'b1; wr_data = 8'h42;
    tick();
    wr_valid = 1'b0;
    got[1] = line;
    for (int k = 2; k < 21; k++) begin
      tick();
      got[k] = line;
    end
    want = {1'b1, 1'b1, 8'h42, 1'b0, 1'b1, 8'h41, 1'b0};
    check("t6_line", 32'(got), 32'(want));
    check("t6_idle_enable", 32'(tx_enable), 0);

    push(8'h55);
    repeat (3) tick();
    check("t6_busy_count", 32'(count), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_count", 32'(count), 0);
    check("t6_rst_enable", 32'(tx_enable), 0);
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
